// File: rtl/osd_num_writer_if.sv
// Request/status and character-RAM write bundle shared by OSD page sequencers
// and the number writer.
interface osd_num_writer_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        mode;
  logic [7:0]        min_width;
  logic              zero_pad;
  logic              upper;
  logic              plus_sign;
  logic [WIDTH-1:0]  value;
  logic              char_we;
  logic [ADDR_W-1:0] char_addr;
  logic [7:0]        char_data;
  logic [7:0]        length;

  modport master (
    output start, base_addr, mode, min_width, zero_pad, upper, plus_sign, value,
    input  busy, done, char_we, char_addr, char_data, length
  );

  modport slave (
    input  start, base_addr, mode, min_width, zero_pad, upper, plus_sign, value,
    output busy, done, char_we, char_addr, char_data, length
  );
endinterface

// File: rtl/osd_num_writer.sv
// Converts one value to a padded ASCII field (udec/sdec/hex/bin) and streams it
// into OSD character RAM, one character per cycle at consecutive addresses.
module osd_num_writer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  osd_num_writer_if.slave bus
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ModeUdec = 2'd0;
  localparam logic [1:0] ModeSdec = 2'd1;
  localparam logic [1:0] ModeHex  = 2'd2;
  localparam logic [1:0] ModeBin  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StPad,
    StSign,
    StDigit,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_q;
  logic [7:0]        min_width_q;
  logic              zero_pad_q;
  logic              upper_q;
  logic              sign_en_q;
  logic [7:0]        sign_char_q;
  logic [WIDTH-1:0]  mag_q;
  logic [3:0]        rem_q;
  logic [7:0]        bit_cnt_q;
  logic [7:0]        ndig_q;
  logic [7:0]        pad_cnt_q;
  logic [7:0]        dig_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        length_q;
  logic [3:0]        dig_buf [WIDTH];

  // Conversion datapath
  logic [63:0]      mag_ext;
  logic [4:0]       rem_shift;
  logic             dec_ge;
  logic [3:0]       rem_new;
  logic [WIDTH-1:0] mag_next;
  logic             digit_ready;
  logic [3:0]       digit_val;
  logic             conv_last;
  logic [7:0]       ndig_new;
  logic [7:0]       body_len;
  logic [7:0]       field_len;
  logic [7:0]       pad_len;
  state_e           first_phase;

  // Emission datapath
  logic       we;
  logic [7:0] data;
  logic [3:0] cur_dig;

  function automatic logic [7:0] to_ascii(input logic [3:0] d, input logic up);
    if (d < 4'd10) begin
      return 8'h30 + {4'b0000, d};
    end
    // 0x37 + 10 = 'A', 0x57 + 10 = 'a'
    return (up ? 8'h37 : 8'h57) + {4'b0000, d};
  endfunction

  always_comb begin
    mag_ext     = 64'(mag_q);
    rem_shift   = {rem_q, mag_q[WIDTH-1]};
    dec_ge      = (rem_shift >= 5'd10);
    rem_new     = dec_ge ? 4'(rem_shift - 5'd10) : rem_shift[3:0];
    digit_ready = 1'b0;
    digit_val   = 4'd0;
    mag_next    = mag_q;
    unique case (mode_q)
      ModeHex: begin
        digit_ready = 1'b1;
        digit_val   = mag_ext[3:0];
        mag_next    = WIDTH'(mag_ext >> 4);
      end
      ModeBin: begin
        digit_ready = 1'b1;
        digit_val   = {3'b000, mag_q[0]};
        mag_next    = mag_q >> 1;
      end
      default: begin
        // Restoring divide by 10: the dividend shifts out MSB-first while the
        // quotient bits shift in at the LSB, so mag_q ends up as the quotient.
        digit_ready = (bit_cnt_q == 8'(WIDTH - 1));
        digit_val   = rem_new;
        mag_next    = {mag_q[WIDTH-2:0], dec_ge};
      end
    endcase
    conv_last = digit_ready && (mag_next == '0);

    ndig_new  = ndig_q + 8'd1;
    body_len  = ndig_new + {7'b0, sign_en_q};
    field_len = (min_width_q > body_len) ? min_width_q : body_len;
    pad_len   = field_len - body_len;

    if (!zero_pad_q && (pad_len != 8'd0)) begin
      first_phase = StPad;
    end else if (sign_en_q) begin
      first_phase = StSign;
    end else if (pad_len != 8'd0) begin
      first_phase = StPad;
    end else begin
      first_phase = StDigit;
    end
  end

  assign cur_dig = dig_buf[dig_idx_q[IdxW-1:0]];

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    data    = 8'h00;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StConvert;
        end
      end
      StConvert: begin
        if (conv_last) begin
          state_d = first_phase;
        end
      end
      StPad: begin
        we   = 1'b1;
        data = zero_pad_q ? 8'h30 : 8'h20;
        if (pad_cnt_q == 8'd1) begin
          state_d = (!zero_pad_q && sign_en_q) ? StSign : StDigit;
        end
      end
      StSign: begin
        we      = 1'b1;
        data    = sign_char_q;
        state_d = (zero_pad_q && (pad_cnt_q != 8'd0)) ? StPad : StDigit;
      end
      StDigit: begin
        we   = 1'b1;
        data = to_ascii(cur_dig, upper_q);
        if (dig_idx_q == 8'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= ModeUdec;
      min_width_q <= 8'd0;
      zero_pad_q  <= 1'b0;
      upper_q     <= 1'b0;
      sign_en_q   <= 1'b0;
      sign_char_q <= 8'h00;
      mag_q       <= '0;
      rem_q       <= 4'd0;
      bit_cnt_q   <= 8'd0;
      ndig_q      <= 8'd0;
      pad_cnt_q   <= 8'd0;
      dig_idx_q   <= 8'd0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      length_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            mode_q      <= bus.mode;
            min_width_q <= bus.min_width;
            zero_pad_q  <= bus.zero_pad;
            upper_q     <= bus.upper;
            addr_q      <= bus.base_addr;
            sign_en_q   <= (bus.mode == ModeSdec) && (bus.value[WIDTH-1] || bus.plus_sign);
            sign_char_q <= bus.value[WIDTH-1] ? 8'h2D : 8'h2B;
            mag_q       <= ((bus.mode == ModeSdec) && bus.value[WIDTH-1]) ?
                           (~bus.value) + WIDTH'(1) : bus.value;
            rem_q       <= 4'd0;
            bit_cnt_q   <= 8'd0;
            ndig_q      <= 8'd0;
          end
        end
        StConvert: begin
          mag_q <= mag_next;
          if ((mode_q == ModeUdec) || (mode_q == ModeSdec)) begin
            rem_q     <= digit_ready ? 4'd0 : rem_new;
            bit_cnt_q <= digit_ready ? 8'd0 : bit_cnt_q + 8'd1;
          end
          if (digit_ready) begin
            ndig_q <= ndig_new;
          end
          if (conv_last) begin
            pad_cnt_q <= pad_len;
            dig_idx_q <= ndig_q;
            len_q     <= field_len;
          end
        end
        StPad: begin
          pad_cnt_q <= pad_cnt_q - 8'd1;
          addr_q    <= addr_q + ADDR_W'(1);
        end
        StSign: begin
          addr_q <= addr_q + ADDR_W'(1);
        end
        StDigit: begin
          addr_q    <= addr_q + ADDR_W'(1);
          dig_idx_q <= dig_idx_q - 8'd1;
          if (dig_idx_q == 8'd0) begin
            length_q <= len_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Digit storage needs no reset: it is always written before it is read.
  always_ff @(posedge clk) begin
    if ((state_q == StConvert) && digit_ready) begin
      dig_buf[ndig_q[IdxW-1:0]] <= digit_val;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.char_we   = we;
  assign bus.char_addr = we ? addr_q : '0;
  assign bus.char_data = data;
  assign bus.length    = length_q;

endmodule

// File: tb/tb_osd_num_writer.sv
// Directed bench for osd_num_writer: a 32-bit and an 8-bit instance, character
// writes captured by a monitor and compared against hand-written strings.
module tb_osd_num_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  osd_num_writer_if #(.WIDTH(32), .ADDR_W(16)) b32 ();
  osd_num_writer_if #(.WIDTH(8),  .ADDR_W(16)) b8 ();

  osd_num_writer #(.WIDTH(32), .ADDR_W(16)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  osd_num_writer #(.WIDTH(8),  .ADDR_W(16)) dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  bit          sel8 = 1'b0;
  byte         wdata[$];
  logic [15:0] waddr[$];
  int          wcyc[$];
  int          done_cyc = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (sel8 ? b8.char_we : b32.char_we) begin
      wdata.push_back(sel8 ? b8.char_data : b32.char_data);
      waddr.push_back(sel8 ? b8.char_addr : b32.char_addr);
      wcyc.push_back(cyc);
    end
    if (sel8 ? b8.done : b32.done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic chk_int(input string tag, input longint got, input longint exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string got, input string exp);
    n_cmp++;
    assert (got == exp) else begin
      n_bad++;
      $error("FAIL %s: got \"%s\" want \"%s\"", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s8, input logic [1:0] m, input logic [7:0] mw,
                       input bit zp, input bit up, input bit ps, input logic [63:0] v,
                       input logic [15:0] base, input bit st);
    if (s8) begin
      b8.mode = m; b8.min_width = mw; b8.zero_pad = zp; b8.upper = up;
      b8.plus_sign = ps; b8.value = v[7:0]; b8.base_addr = base; b8.start = st;
    end else begin
      b32.mode = m; b32.min_width = mw; b32.zero_pad = zp; b32.upper = up;
      b32.plus_sign = ps; b32.value = v[31:0]; b32.base_addr = base; b32.start = st;
    end
  endtask

  function automatic string captured();
    string s = "";
    foreach (wdata[i]) s = $sformatf("%s%c", s, wdata[i]);
    return s;
  endfunction

  task automatic clear_capture();
    wdata.delete();
    waddr.delete();
    wcyc.delete();
    done_cnt = 0;
  endtask

  task automatic run(input string tag, input bit s8, input logic [1:0] m, input logic [7:0] mw,
                     input bit zp, input bit up, input bit ps, input logic [63:0] v,
                     input logic [15:0] base, input string exp, input bit mid);
    bit addr_ok;
    int n;
    sel8 = s8;
    clear_capture();
    @(negedge clk);
    drive(s8, m, mw, zp, up, ps, v, base, 1'b1);
    @(negedge clk);
    drive(s8, m, mw, zp, up, ps, v, base, 1'b0);
    chk_int({tag, ".busy_rise"}, longint'(s8 ? b8.busy : b32.busy), 1);
    if (mid) begin
      // Conflicting request while busy must be ignored.
      repeat (2) @(negedge clk);
      drive(s8, 2'd3, 8'd20, ~zp, ~up, 1'b1, ~v, base + 16'h40, 1'b1);
      @(negedge clk);
      drive(s8, 2'd3, 8'd20, ~zp, ~up, 1'b1, ~v, base + 16'h40, 1'b0);
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
    chk_int({tag, ".done_seen"}, longint'(done_cnt), 1);
    @(negedge clk);
    chk_int({tag, ".busy_fall"}, longint'(s8 ? b8.busy : b32.busy), 0);
    chk_int({tag, ".done_once"}, longint'(done_cnt), 1);
    chk_str({tag, ".text"}, captured(), exp);
    chk_int({tag, ".length"}, longint'(s8 ? b8.length : b32.length), longint'(exp.len()));
    n = wdata.size();
    addr_ok = 1'b1;
    foreach (waddr[i]) if (waddr[i] !== 16'(base + 16'(i))) addr_ok = 1'b0;
    chk_int({tag, ".addr_seq"}, longint'(addr_ok), 1);
    if (n > 0) begin
      chk_int({tag, ".no_gaps"}, longint'(wcyc[n-1] - wcyc[0]), longint'(n - 1));
      chk_int({tag, ".done_after_last"}, longint'(done_cyc - wcyc[n-1]), 1);
    end
  endtask

  initial begin
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 64'd0, 16'd0, 1'b0);
    drive(1'b1, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 64'd0, 16'd0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_int("rst.busy", longint'(b32.busy), 0);
    chk_int("rst.done", longint'(b32.done), 0);
    chk_int("rst.char_we", longint'(b32.char_we), 0);
    chk_int("rst.char_addr", longint'(b32.char_addr), 0);
    chk_int("rst.char_data", longint'(b32.char_data), 0);
    chk_int("rst.length", longint'(b32.length), 0);
    chk_int("rst.busy8", longint'(b8.busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run("sdec_neg_zp", 0, 2'd1, 8'd5, 1, 0, 0, 64'hFFFF_FFD6, 16'h0100, "-0042", 0);
    chk_int("sdec_neg_zp.first_addr", longint'(waddr[0]), 'h0100);
    chk_int("sdec_neg_zp.last_addr", longint'(waddr[4]), 'h0104);
    run("sdec_neg_sp", 0, 2'd1, 8'd5, 0, 0, 0, 64'hFFFF_FFD6, 16'h0200, "  -42", 0);
    run("sdec_plus", 0, 2'd1, 8'd0, 0, 0, 1, 64'd7, 16'h0010, "+7", 0);
    run("sdec_pos_zp", 0, 2'd1, 8'd4, 1, 0, 0, 64'd42, 16'h0020, "0042", 0);
    run("hex_upper", 0, 2'd2, 8'd8, 1, 1, 0, 64'h0000_BEEF, 16'h0300, "0000BEEF", 0);
    run("hex_lower", 0, 2'd2, 8'd0, 0, 0, 0, 64'h0000_BEEF, 16'h0300, "beef", 0);
    run("bin_5", 0, 2'd3, 8'd0, 0, 0, 0, 64'd5, 16'h0400, "101", 0);
    run("udec_zero", 0, 2'd0, 8'd0, 0, 0, 0, 64'd0, 16'h0500, "0", 0);
    run("sdec8_min", 1, 2'd1, 8'd0, 0, 0, 0, 64'h80, 16'h0600, "-128", 0);
    run("udec_max", 0, 2'd0, 8'd0, 0, 0, 0, 64'hFFFF_FFFF, 16'h0700, "4294967295", 0);
    run("udec_wrap", 0, 2'd0, 8'd0, 0, 0, 0, 64'd123, 16'hFFFE, "123", 0);
    chk_int("udec_wrap.addr0", longint'(waddr[0]), 'hFFFE);
    chk_int("udec_wrap.addr2", longint'(waddr[2]), 'h0000);
    run("mid_start", 0, 2'd0, 8'd7, 0, 0, 0, 64'd98765, 16'h0800, "  98765", 1);

    // Reset during emission of "12345" after two writes
    sel8 = 1'b0;
    clear_capture();
    @(negedge clk);
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 64'd12345, 16'h0900, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 64'd12345, 16'h0900, 1'b0);
    for (int i = 0; i < 3000 && wdata.size() < 2; i++) @(posedge clk);
    chk_int("rst_mid.two_writes", longint'(wdata.size()), 2);
    #1 rst = 1'b1;
    #1;
    chk_int("rst_mid.char_we", longint'(b32.char_we), 0);
    chk_int("rst_mid.busy", longint'(b32.busy), 0);
    chk_int("rst_mid.done", longint'(b32.done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_str("rst_mid.text", captured(), "12");
    chk_int("rst_mid.done_cnt", longint'(done_cnt), 0);
    chk_int("rst_mid.length", longint'(b32.length), 0);
    run("after_rst", 0, 2'd0, 8'd0, 0, 0, 0, 64'd12345, 16'h0900, "12345", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
